// File: rtl/door_lock_pkg.sv
// Shared constants for the door-lock motor path.
// State codes, direction codes and H-bridge drive patterns.
package door_lock_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN_CW  = 3'd1;
  localparam logic [2:0] S_RUN_ACW = 3'd2;
  localparam logic [2:0] S_BRAKE   = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_ACW  = 2'd2;

  // {A,B} leg patterns; 2'b11 is never used
  localparam logic [1:0] COAST     = 2'b00;
  localparam logic [1:0] DRIVE_CW  = 2'b10;
  localparam logic [1:0] DRIVE_ACW = 2'b01;

  function automatic logic [1:0] drive_of(
    input logic [2:0] s
  );
    logic [1:0] d;
    d = COAST;
    if (s == S_RUN_CW) d = DRIVE_CW;
    else if (s == S_RUN_ACW) d = DRIVE_ACW;
    return d;
  endfunction

endpackage

// File: rtl/door_motor_driver_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Width is parameterized; flops reset low.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ff1_q;
  logic [W-1:0] ff2_q;

  // two-stage metastability filter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/door_motor_driver.sv
// H-bridge driver for the door bolt motor.
// Runs to limit, brakes on reversal, latches faults.
module door_motor_driver
  import door_lock_pkg::*;
#(
  parameter int RUN_TIMEOUT = 1000,
  parameter int DEADTIME    = 8,
  parameter int CNT_W       = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CMD_CW,
  input  logic CMD_ACW,
  input  logic LIM_LOCKED,
  input  logic LIM_UNLOCKED,
  input  logic CLR_FAULT,
  output logic MOT_A,
  output logic MOT_B,
  output logic BUSY,
  output logic LOCKED,
  output logic UNLOCKED,
  output logic FAULT
);

  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DT_LAST =
    CNT_W'(DEADTIME - 1);

  logic [1:0]       lim_s;
  logic             locked_s;
  logic             unlocked_s;
  logic             sens_err;
  logic [1:0]       cmd;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       mot_q;
  logic             busy_q;
  logic             fault_q;

  sync_2ff #(
    .W(2)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   ({LIM_LOCKED, LIM_UNLOCKED}),
    .q_o   (lim_s)
  );

  assign locked_s   = lim_s[1];
  assign unlocked_s = lim_s[0];
  assign sens_err   = locked_s & unlocked_s;

  // decode command pulses; both high means none
  always_comb begin
    cmd = DIR_NONE;
    if (CMD_CW && !CMD_ACW) cmd = DIR_CW;
    else if (CMD_ACW && !CMD_CW) cmd = DIR_ACW;
  end

  // next state, move counter and pending reversal
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        pend_d = DIR_NONE;
        if (sens_err)
          state_d = S_FAULT;
        else if (cmd == DIR_CW && !locked_s)
          state_d = S_RUN_CW;
        else if (cmd == DIR_ACW && !unlocked_s)
          state_d = S_RUN_ACW;
      end
      S_RUN_CW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sens_err)
          state_d = S_FAULT;
        else if (locked_s)
          state_d = S_IDLE;
        else if (cnt_q == RUN_LAST)
          state_d = S_FAULT;
        else if (cmd == DIR_ACW) begin
          state_d = S_BRAKE;
          pend_d  = DIR_ACW;
        end
      end
      S_RUN_ACW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sens_err)
          state_d = S_FAULT;
        else if (unlocked_s)
          state_d = S_IDLE;
        else if (cnt_q == RUN_LAST)
          state_d = S_FAULT;
        else if (cmd == DIR_CW) begin
          state_d = S_BRAKE;
          pend_d  = DIR_CW;
        end
      end
      S_BRAKE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cmd != DIR_NONE) pend_d = cmd;
        if (sens_err)
          state_d = S_FAULT;
        else if (cnt_q == DT_LAST) begin
          if (pend_d == DIR_CW && !locked_s)
            state_d = S_RUN_CW;
          else if (pend_d == DIR_ACW && !unlocked_s)
            state_d = S_RUN_ACW;
          else
            state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        pend_d = DIR_NONE;
        if (CLR_FAULT) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = DIR_NONE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d != S_BRAKE) pend_d = DIR_NONE;
  end

  // state, counter and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= DIR_NONE;
      mot_q   <= COAST;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mot_q   <= drive_of(state_d);
      busy_q  <= (state_d == S_RUN_CW) ||
                 (state_d == S_RUN_ACW) ||
                 (state_d == S_BRAKE);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign MOT_A    = mot_q[1];
  assign MOT_B    = mot_q[0];
  assign BUSY     = busy_q;
  assign FAULT    = fault_q;
  assign LOCKED   = locked_s;
  assign UNLOCKED = unlocked_s;

endmodule
